// File: rtl/fabscalar_pkg.sv
// Shared front-end definitions: decoded packet layout and decode width.
// FETCH_BANDWIDTH falls back to 4 (8 decode slots) when not set by the build.
`ifndef FETCH_BANDWIDTH
`define FETCH_BANDWIDTH 4
`endif

package fabscalar_pkg;

    localparam int PC_W      = 32;
    localparam int OPCODE_W  = 8;
    localparam int LOG_REG_W = 6;
    localparam int IMM_W     = 16;

    // Width of one decoded packet as carried into the instruction buffer.
    localparam int DECODED_PKT_W = PC_W + OPCODE_W + 3 * LOG_REG_W + IMM_W + 1;

    localparam int SLOTS_DEC = 2 * `FETCH_BANDWIDTH;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [OPCODE_W-1:0]  opcode;
        logic [LOG_REG_W-1:0] src1;
        logic [LOG_REG_W-1:0] src2;
        logic [LOG_REG_W-1:0] dest;
        logic [IMM_W-1:0]     imm;
        logic                 is_branch;
    } decoded_pkt_t;

endpackage

// File: rtl/slot_compactor.sv
// Combinational slot compactor: moves the valid slots of a sparse vector,
// in order, into slots 0..n-1 and produces the contiguous vector and count.
module slot_compactor
    import fabscalar_pkg::*;
#(
    parameter int SLOTS = SLOTS_DEC,
    parameter int PKT_W = DECODED_PKT_W,
    parameter int CNT_W = $clog2(SLOTS + 1)
) (
    input  logic [SLOTS-1:0]       vector_i,
    input  logic [SLOTS*PKT_W-1:0] packets_i,
    output logic [SLOTS*PKT_W-1:0] packets_o,
    output logic [SLOTS-1:0]       vector_o,
    output logic [CNT_W-1:0]       cnt_o
);

    logic [CNT_W-1:0] pos [SLOTS];

    // Prefix popcount: pos[k] is the output slot input slot k lands in.
    always_comb begin
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            pos[k] = acc;
            acc    = acc + CNT_W'(vector_i[k]);
        end
        cnt_o = acc;
    end

    // Per-output-slot mux; at most one input slot matches each output slot.
    always_comb begin
        packets_o = '0;
        for (int unsigned j = 0; j < SLOTS; j++) begin
            for (int unsigned k = 0; k < SLOTS; k++) begin
                if (vector_i[k] && (pos[k] == CNT_W'(j))) begin
                    packets_o[j*PKT_W +: PKT_W] = packets_o[j*PKT_W +: PKT_W]
                                                | packets_i[k*PKT_W +: PKT_W];
                end
            end
        end
    end

    // Contiguous valid vector 2^n-1.
    always_comb begin
        vector_o = '0;
        for (int unsigned j = 0; j < SLOTS; j++) begin
            vector_o[j] = (CNT_W'(j) < cnt_o);
        end
    end

endmodule

// File: rtl/decode_slot_compactor.sv
// Registered decode-to-buffer stage: compacts sparse decode slots, holds the
// bundle while the instruction buffer stalls, and back-pressures the decoder.
// Optional perf counters are built when DECODE_COMPACT_PERF_EN is defined.
module decode_slot_compactor
    import fabscalar_pkg::*;
#(
    parameter int SLOTS = SLOTS_DEC,
    parameter int PKT_W = DECODED_PKT_W,
    parameter int CNT_W = $clog2(SLOTS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   valid_i,
    input  logic [SLOTS-1:0]       vector_i,
    input  logic [SLOTS*PKT_W-1:0] packets_i,
    output logic                   stall_o,
    input  logic                   stallFetch_i,
    output logic                   decodeReady_o,
    output logic [SLOTS-1:0]       decodedVector_o,
    output logic [SLOTS*PKT_W-1:0] packets_o,
    output logic [CNT_W-1:0]       instCount_o
`ifdef DECODE_COMPACT_PERF_EN
    ,
    output logic [31:0]            perfInsts_o,
    output logic [31:0]            perfStalls_o
`endif
);

    logic [SLOTS*PKT_W-1:0] cmp_pkts;
    logic [SLOTS-1:0]       cmp_vec;
    logic [CNT_W-1:0]       cmp_cnt;
    logic                   stall;
    logic                   load;

    logic                   ready_q, ready_d;
    logic [SLOTS-1:0]       vec_q,   vec_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [SLOTS*PKT_W-1:0] pkts_q,  pkts_d;

    slot_compactor #(
        .SLOTS (SLOTS),
        .PKT_W (PKT_W),
        .CNT_W (CNT_W)
    ) u_compact (
        .vector_i  (vector_i),
        .packets_i (packets_i),
        .packets_o (cmp_pkts),
        .vector_o  (cmp_vec),
        .cnt_o     (cmp_cnt)
    );

    // Back-pressure and load qualification.
    always_comb begin
        stall = ready_q & stallFetch_i;
        load  = valid_i & (cmp_cnt != '0) & ~stall;
    end

    // Next output bundle: flush, then stall-hold, then load, else go idle.
    always_comb begin
        ready_d = ready_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pkts_d  = pkts_q;
        if (flush_i) begin
            ready_d = 1'b0;
            vec_d   = '0;
            cnt_d   = '0;
        end else if (!stall) begin
            if (load) begin
                ready_d = 1'b1;
                vec_d   = cmp_vec;
                cnt_d   = cmp_cnt;
                pkts_d  = cmp_pkts;
            end else begin
                // Stale packets stay behind a zero vector.
                ready_d = 1'b0;
                vec_d   = '0;
                cnt_d   = '0;
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            vec_q   <= '0;
            cnt_q   <= '0;
            pkts_q  <= '0;
        end else begin
            ready_q <= ready_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pkts_q  <= pkts_d;
        end
    end

    assign stall_o         = stall;
    assign decodeReady_o   = ready_q;
    assign decodedVector_o = vec_q;
    assign instCount_o     = cnt_q;
    assign packets_o       = pkts_q;

`ifdef DECODE_COMPACT_PERF_EN
    logic [31:0] insts_q,  insts_d;
    logic [31:0] stalls_q, stalls_d;

    // Perf counters: a flushed input is dropped, so it is not counted as loaded.
    always_comb begin
        insts_d  = insts_q;
        stalls_d = stalls_q;
        if (load && !flush_i) begin
            insts_d = insts_q + 32'(cmp_cnt);
        end
        if (stall) begin
            stalls_d = stalls_q + 32'd1;
        end
    end

    // Perf counter registers, cleared by reset only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            insts_q  <= '0;
            stalls_q <= '0;
        end else begin
            insts_q  <= insts_d;
            stalls_q <= stalls_d;
        end
    end

    assign perfInsts_o  = insts_q;
    assign perfStalls_o = stalls_q;
`endif

endmodule

// File: tb/tb_decode_slot_compactor.sv
// Directed scoreboard bench for decode_slot_compactor.
// Perf counter checks are included when DECODE_COMPACT_PERF_EN is defined.
module tb_decode_slot_compactor;
    import fabscalar_pkg::*;

    localparam int SLOTS = SLOTS_DEC;
    localparam int PKT_W = DECODED_PKT_W;
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam int BUS_W = SLOTS * PKT_W;

    typedef struct packed {
        logic             ready;
        logic [SLOTS-1:0] vec;
        logic [CNT_W-1:0] cnt;
        logic [BUS_W-1:0] pkts;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush_i;
    logic             valid_i;
    logic [SLOTS-1:0] vector_i;
    logic [BUS_W-1:0] packets_i;
    logic             stall_o;
    logic             stallFetch_i;
    logic             decodeReady_o;
    logic [SLOTS-1:0] decodedVector_o;
    logic [BUS_W-1:0] packets_o;
    logic [CNT_W-1:0] instCount_o;
`ifdef DECODE_COMPACT_PERF_EN
    logic [31:0]      perfInsts_o;
    logic [31:0]      perfStalls_o;
`endif

    decode_slot_compactor #(
        .SLOTS (SLOTS),
        .PKT_W (PKT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush_i),
        .valid_i         (valid_i),
        .vector_i        (vector_i),
        .packets_i       (packets_i),
        .stall_o         (stall_o),
        .stallFetch_i    (stallFetch_i),
        .decodeReady_o   (decodeReady_o),
        .decodedVector_o (decodedVector_o),
        .packets_o       (packets_o),
        .instCount_o     (instCount_o)
`ifdef DECODE_COMPACT_PERF_EN
        ,
        .perfInsts_o     (perfInsts_o),
        .perfStalls_o    (perfStalls_o)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference state of the output register.
    logic             m_ready;
    logic [SLOTS-1:0] m_vec;
    logic [CNT_W-1:0] m_cnt;
    logic [BUS_W-1:0] m_pkts;
    logic [31:0]      m_insts;
    logic [31:0]      m_stalls;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Random packets with input slot index in the low byte.
    task automatic tagged_pkts(output logic [BUS_W-1:0] p);
        logic [95:0] r;
        p = '0;
        for (int k = 0; k < SLOTS; k++) begin
            r = {$urandom, $urandom, $urandom};
            r[7:0] = 8'(k);
            p[k*PKT_W +: PKT_W] = r[PKT_W-1:0];
        end
    endtask

    // Reference compaction: walk input slots and append each valid one.
    task automatic ref_compact(input logic [SLOTS-1:0] vec, input logic [BUS_W-1:0] p,
                               output logic [SLOTS-1:0] rv, output int rc,
                               output logic [BUS_W-1:0] rp);
        int n;
        n  = 0;
        rp = '0;
        rv = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (vec[k]) begin
                rp[n*PKT_W +: PKT_W] = p[k*PKT_W +: PKT_W];
                n++;
            end
        end
        for (int i = 0; i < n; i++) rv[i] = 1'b1;
        rc = n;
    endtask

    task automatic model_reset();
        m_ready  = 1'b0;
        m_vec    = '0;
        m_cnt    = '0;
        m_pkts   = '0;
        m_insts  = '0;
        m_stalls = '0;
        sb.delete();
    endtask

    // One clock of stimulus: drive, check stall_o, predict, clock, compare.
    task automatic step(input string tag, input logic v, input logic [SLOTS-1:0] vec,
                        input logic [BUS_W-1:0] p, input logic sf, input logic fl);
        logic [SLOTS-1:0] rv;
        int               rc;
        logic [BUS_W-1:0] rp;
        logic             exp_stall;
        exp_t             e;
        valid_i      = v;
        vector_i     = vec;
        packets_i    = p;
        stallFetch_i = sf;
        flush_i      = fl;
        #1;
        exp_stall = m_ready & sf;
        chk({tag, ".stall"}, 64'(stall_o), 64'(exp_stall));
        ref_compact(vec, p, rv, rc, rp);
        if (exp_stall) m_stalls = m_stalls + 32'd1;
        if (fl) begin
            m_ready = 1'b0; m_vec = '0; m_cnt = '0;
        end else if (exp_stall) begin
            // held
        end else if (v && rc != 0) begin
            m_ready = 1'b1; m_vec = rv; m_cnt = CNT_W'(rc); m_pkts = rp;
            m_insts = m_insts + 32'(rc);
        end else begin
            m_ready = 1'b0; m_vec = '0; m_cnt = '0;
        end
        e.ready = m_ready; e.vec = m_vec; e.cnt = m_cnt; e.pkts = m_pkts;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".ready"}, 64'(decodeReady_o), 64'(e.ready));
        chk({tag, ".vec"}, 64'(decodedVector_o), 64'(e.vec));
        chk({tag, ".cnt"}, 64'(instCount_o), 64'(e.cnt));
        if (e.ready) chk_bus({tag, ".pkts"}, packets_o, e.pkts);
    endtask

    initial begin
        logic [BUS_W-1:0] pa, pb, pc, pd, snap;

        reset = 1'b0; flush_i = 1'b0; valid_i = 1'b0; vector_i = '0;
        packets_i = '0; stallFetch_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 64'(decodeReady_o), 64'd0);
        chk("rst.vec", 64'(decodedVector_o), 64'd0);
        chk("rst.cnt", 64'(instCount_o), 64'd0);
        chk_bus("rst.pkts", packets_o, '0);
        reset = 1'b1;

        // Sparse compaction.
        tagged_pkts(pa);
        step("sparse", 1'b1, 8'b1010_0101, pa, 1'b0, 1'b0);
        chk("sparse.vec_const", 64'(decodedVector_o), 64'h0F);
        chk("sparse.cnt_const", 64'(instCount_o), 64'd4);
        snap = packets_o;
        chk("sparse.slot3_tag", 64'(snap[3*PKT_W +: 8]), 64'd7);
        chk("sparse.slot4_zero", 64'(snap[4*PKT_W +: PKT_W]), 64'd0);

        // Hold while the buffer stalls, new bundle waiting on the input.
        tagged_pkts(pa);
        tagged_pkts(pb);
        step("hold.load", 1'b1, 8'h3C, pa, 1'b0, 1'b0);
        step("hold.s1", 1'b1, 8'hC3, pb, 1'b1, 1'b0);
        step("hold.s2", 1'b1, 8'hC3, pb, 1'b1, 1'b0);
        step("hold.s3", 1'b1, 8'hC3, pb, 1'b1, 1'b0);
        step("hold.release", 1'b1, 8'hC3, pb, 1'b0, 1'b0);
        step("hold.idle", 1'b0, 8'h00, pb, 1'b0, 1'b0);

        // Flush beats stall and load; afterwards stall_o is low and a bundle loads.
        tagged_pkts(pa); tagged_pkts(pb); tagged_pkts(pc); tagged_pkts(pd);
        step("flush.load", 1'b1, 8'h11, pa, 1'b0, 1'b0);
        step("flush.hit", 1'b1, 8'h22, pb, 1'b1, 1'b1);
        step("flush.after", 1'b1, 8'h44, pc, 1'b1, 1'b0);
        step("flush.hold", 1'b1, 8'h88, pd, 1'b1, 1'b0);
        step("flush.idle", 1'b0, 8'h00, pd, 1'b0, 1'b0);

        // Edge vectors.
        tagged_pkts(pa);
        step("edge.ff", 1'b1, 8'hFF, pa, 1'b0, 1'b0);
        chk("edge.ff_cnt", 64'(instCount_o), 64'd8);
        tagged_pkts(pa);
        step("edge.80", 1'b1, 8'h80, pa, 1'b0, 1'b0);
        snap = packets_o;
        chk("edge.80_slot0_tag", 64'(snap[7:0]), 64'd7);
        step("edge.00", 1'b1, 8'h00, pa, 1'b0, 1'b0);
        step("edge.00b", 1'b1, 8'h00, pa, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a stall.
        tagged_pkts(pa);
        step("rstmid.load", 1'b1, 8'h0F, pa, 1'b0, 1'b0);
        step("rstmid.stall", 1'b0, 8'h00, pa, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        chk("rstmid.ready", 64'(decodeReady_o), 64'd0);
        chk("rstmid.vec", 64'(decodedVector_o), 64'd0);
        chk("rstmid.cnt", 64'(instCount_o), 64'd0);
        chk("rstmid.stall_o", 64'(stall_o), 64'd0);
        chk_bus("rstmid.pkts", packets_o, '0);
        model_reset();
`ifdef DECODE_COMPACT_PERF_EN
        chk("rstmid.perf_insts", 64'(perfInsts_o), 64'd0);
        chk("rstmid.perf_stalls", 64'(perfStalls_o), 64'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        stallFetch_i = 1'b0;

        // Counts 3, 8, 1 plus two stall cycles, then a flush.
        tagged_pkts(pa);
        step("perf.l3", 1'b1, 8'h07, pa, 1'b0, 1'b0);
        step("perf.l8", 1'b1, 8'hFF, pa, 1'b0, 1'b0);
        step("perf.l1", 1'b1, 8'h01, pa, 1'b0, 1'b0);
        step("perf.st1", 1'b0, 8'h00, pa, 1'b1, 1'b0);
        step("perf.st2", 1'b0, 8'h00, pa, 1'b1, 1'b0);
`ifdef DECODE_COMPACT_PERF_EN
        chk("perf.insts", 64'(perfInsts_o), 64'd12);
        chk("perf.stalls", 64'(perfStalls_o), 64'd2);
        chk("perf.insts_model", 64'(perfInsts_o), 64'(m_insts));
`endif
        step("perf.flush", 1'b1, 8'h3F, pa, 1'b0, 1'b1);
`ifdef DECODE_COMPACT_PERF_EN
        chk("perf.insts_flush", 64'(perfInsts_o), 64'd12);
        chk("perf.stalls_flush", 64'(perfStalls_o), 64'd2);
`endif
        step("final.idle", 1'b0, 8'h00, pa, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
